// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and FSM state encoding for the instruction-fetch stage
package if_fetch_pkg;
  localparam int EXCEP_TYPE_BUS = 6;
  localparam int IF_EXC_ADEL = 0;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/inst_req_fsm.sv
// inst_req_fsm: REQ/WAIT/HOLD bus sequencer; drops the response of a request orphaned by an exception
module inst_req_fsm
  import if_fetch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic misaligned,
  input  logic exception,
  input  logic inst_addr_ok,
  input  logic inst_data_ok,
  output logic inst_req,
  output logic capture,
  output logic adel_hit,
  output logic consume
);
  fetch_state_e state;
  logic discard;
  logic run;
  logic accept;
  logic in_flight;
  assign inst_req  = run && state == S_REQ && !misaligned;
  assign accept    = inst_req && inst_addr_ok;
  assign adel_hit  = run && state == S_REQ && misaligned && !exception;
  assign capture   = state == S_WAIT && inst_data_ok && !discard && !exception;
  assign consume   = state == S_HOLD && !hold && !exception;
  // a request survives an exception unless its data lands in the same cycle
  assign in_flight = accept || (state == S_WAIT && !inst_data_ok);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_REQ;
      discard <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (exception) begin
        state   <= in_flight ? S_WAIT : S_REQ;
        discard <= in_flight;
      end else begin
        case (state)
          S_REQ:  state <= accept ? S_WAIT : adel_hit ? S_HOLD : S_REQ;
          S_WAIT: begin
            if (inst_data_ok) begin
              state   <= discard ? S_REQ : S_HOLD;
              discard <= 1'b0;
            end
          end
          S_HOLD: state <= consume ? S_REQ : S_HOLD;
          default: state <= S_REQ;
        endcase
      end
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner and IF/ID producer with delayed-branch and exception redirect.
// Optional fetch address-error detection is enabled by defining IF_ADEL_CHECK_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_fetch_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                stall,
  input  logic                      exception,
  input  logic [31:0]               excep_pc,
  input  logic                      branch_flag,
  input  logic [31:0]               branch_target,
  output logic                      inst_req,
  output logic [31:0]               inst_addr,
  input  logic                      inst_addr_ok,
  input  logic                      inst_data_ok,
  input  logic [31:0]               inst_rdata,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_instr,
  output logic [EXCEP_TYPE_BUS-1:0] if_exception_type,
  output logic                      inst_stall
);
  logic [31:0] pc;
  logic [31:0] br_tgt;
  logic [31:0] instr;
  logic br_pend;
  logic if_valid;
  logic misaligned;
  logic capture;
  logic adel_hit;
  logic consume;
`ifdef IF_ADEL_CHECK_EN
  logic [EXCEP_TYPE_BUS-1:0] exc_type;
  assign misaligned        = |pc[1:0];
  assign inst_addr         = pc;
  assign if_exception_type = exc_type;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_type <= '0;
    else if (exception || capture) exc_type <= '0;
    else if (adel_hit) exc_type <= EXCEP_TYPE_BUS'(1 << IF_EXC_ADEL);
  end
`else
  assign misaligned        = 1'b0;
  assign inst_addr         = {pc[31:2], 2'b00};
  assign if_exception_type = '0;
`endif
  inst_req_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .hold         (|stall),
    .misaligned   (misaligned),
    .exception    (exception),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_req     (inst_req),
    .capture      (capture),
    .adel_hit     (adel_hit),
    .consume      (consume)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      br_pend  <= 1'b0;
      br_tgt   <= '0;
      if_valid <= 1'b0;
      instr    <= '0;
    end else if (exception) begin
      pc       <= excep_pc;
      br_pend  <= 1'b0;
      if_valid <= 1'b0;
    end else begin
      if (capture) begin
        instr    <= inst_rdata;
        if_valid <= 1'b1;
      end
      if (adel_hit) begin
        instr    <= '0;
        if_valid <= 1'b1;
      end
      // a branch seen before the delay slot is consumed waits in br_tgt
      if (consume) begin
        pc       <= br_pend ? br_tgt : branch_flag ? branch_target : pc + 32'd4;
        br_pend  <= 1'b0;
        if_valid <= 1'b0;
      end else if (branch_flag) begin
        br_pend <= 1'b1;
        br_tgt  <= branch_target;
      end
    end
  end
  assign if_pc      = pc;
  assign if_instr   = instr;
  assign inst_stall = !if_valid;
endmodule
